// File: rtl/bist_pkg.sv
// Shared definitions for the BIST address/data stage.
//   PAT_*      : background pattern select encodings
//   PAT_MAX_W  : widest data bus the pattern helper can serve
//   pattern()  : background value for one address, truncated by the caller
package bist_pkg;

  localparam int PAT_MAX_W = 64;

  localparam logic [1:0] PAT_ZERO = 2'b00;
  localparam logic [1:0] PAT_ONES = 2'b01;
  localparam logic [1:0] PAT_CHK  = 2'b10;
  localparam logic [1:0] PAT_ADDR = 2'b11;

  // The result is always PAT_MAX_W wide. Callers zero-extend the address on
  // the way in and truncate the result to their data width on the way out.
  function automatic logic [PAT_MAX_W-1:0] pattern(
    input logic [PAT_MAX_W-1:0] addr,
    input logic [1:0]           sel,
    input logic                 inv
  );
    logic [PAT_MAX_W-1:0] p;
    p = '0;
    case (sel)
      PAT_ZERO: p = '0;
      PAT_ONES: p = '1;
      PAT_CHK: begin
        // Even addresses give ...0101, odd addresses give ...1010.
        for (int i = 0; i < PAT_MAX_W; i++) begin
          p[i] = ~(i[0] ^ addr[0]);
        end
      end
      default: p = addr;
    endcase
    if (inv) begin
      p = ~p;
    end
    return p;
  endfunction

endpackage

// File: rtl/bist_rd_pipe.sv
// Read-compare delay line: carries {valid, expected, addr} for DEPTH cycles
// so it lines up with memory read data of the same latency.
//   clk, rst  : clock, asynchronous active-high reset (clears valid bits)
//   flush     : synchronous clear of all valid bits
//   in_*      : entry captured at the end of the issue cycle
//   out_*     : entry that was issued DEPTH cycles earlier
//
// Flow control: valid-only. An entry is taken whenever in_valid is high at a
// clock edge; there is no ready because the stage never stalls, so one entry
// per cycle flows through at full rate.
module bist_rd_pipe #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_exp,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_exp,
  output logic [ADDR_W-1:0] out_addr
);

  logic [DEPTH-1:0]  valid_r;
  logic [DATA_W-1:0] exp_r  [DEPTH];
  logic [ADDR_W-1:0] addr_r [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= '0;
    end else if (flush) begin
      valid_r <= '0;
    end else begin
      valid_r[0] <= in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        valid_r[i] <= valid_r[i-1];
      end
    end
  end

  // Payload needs no reset: it is only looked at when its valid bit is set.
  always_ff @(posedge clk) begin
    exp_r[0]  <= in_exp;
    addr_r[0] <= in_addr;
    for (int i = 1; i < DEPTH; i++) begin
      exp_r[i]  <= exp_r[i-1];
      addr_r[i] <= addr_r[i-1];
    end
  end

  assign out_valid = valid_r[DEPTH-1];
  assign out_exp   = exp_r[DEPTH-1];
  assign out_addr  = addr_r[DEPTH-1];

endmodule

// File: rtl/bist_addr_gen.sv
// BIST datapath stage: address counter, background pattern generation,
// write strobe, read compare and first-failure capture.
//   clk, rst        : clock, asynchronous active-high reset
//   reset, preset   : controller sync clear (addr 0, flush) / load (addr max)
//   en, up_down     : step the address and issue an access; count direction
//   wr_phase        : 1 write access, 0 read-and-compare access
//   pat_sel, inv    : background select and complement
//   mem_rdata       : memory read data, valid RD_LAT cycles after issue
//   addr            : registered memory address
//   mem_we/mem_wdata: write strobe and data (pattern of the current address)
//   carry           : one-cycle pulse after the wrapping step
//   is_equal        : result of the last compare
//   cmp_valid       : one-cycle pulse when is_equal was just updated
//   fail_seen       : sticky mismatch flag
//   fail_addr       : address of the first mismatch
module bist_addr_gen
  import bist_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reset,
  input  logic              preset,
  input  logic              en,
  input  logic              up_down,
  input  logic              wr_phase,
  input  logic [1:0]        pat_sel,
  input  logic              inv,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              carry,
  output logic              is_equal,
  output logic              cmp_valid,
  output logic              fail_seen,
  output logic [ADDR_W-1:0] fail_addr
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  logic                 step;
  logic                 wrap;
  logic                 rd_issue;
  logic [PAT_MAX_W-1:0] addr_ext;
  logic [DATA_W-1:0]    pat;
  logic                 pipe_valid;
  logic [DATA_W-1:0]    pipe_exp;
  logic [ADDR_W-1:0]    pipe_addr;
  logic                 rd_match;

  // An access only happens when the controller is not clearing or loading.
  assign step = en & ~reset & ~preset;
  assign wrap = up_down ? (addr == ADDR_MAX) : (addr == '0);

  assign addr_ext = PAT_MAX_W'(addr);
  assign pat      = DATA_W'(pattern(addr_ext, pat_sel, inv));

  // ---------------- address counter and terminal count ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr  <= '0;
      carry <= 1'b0;
    end else begin
      if (reset) begin
        addr <= '0;
      end else if (preset) begin
        addr <= ADDR_MAX;
      end else if (en) begin
        addr <= up_down ? addr + 1'b1 : addr - 1'b1;
      end
      carry <= step & wrap;
    end
  end

  // ---------------- write path (pre-step address) ----------------
  assign mem_we    = step & wr_phase;
  assign mem_wdata = pat;

  // ---------------- read issue and alignment ----------------
  assign rd_issue = step & ~wr_phase;

  bist_rd_pipe #(
    .DEPTH  (RD_LAT),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .flush     (reset),
    .in_valid  (rd_issue),
    .in_exp    (pat),
    .in_addr   (addr),
    .out_valid (pipe_valid),
    .out_exp   (pipe_exp),
    .out_addr  (pipe_addr)
  );

  assign rd_match = (mem_rdata == pipe_exp);

  // ---------------- compare result and first-failure capture ----------------
  // A controller reset wins over a compare arriving in the same cycle, so a
  // read that was in flight when reset arrived is never reported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_equal  <= 1'b1;
      cmp_valid <= 1'b0;
      fail_seen <= 1'b0;
      fail_addr <= '0;
    end else if (reset) begin
      is_equal  <= 1'b1;
      cmp_valid <= 1'b0;
      fail_seen <= 1'b0;
      fail_addr <= '0;
    end else if (pipe_valid) begin
      cmp_valid <= 1'b1;
      is_equal  <= rd_match;
      if (!rd_match && !fail_seen) begin
        fail_seen <= 1'b1;
        fail_addr <= pipe_addr;
      end
    end else begin
      cmp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bist_addr_gen.sv
// Bench for bist_addr_gen: two instances (read latency 1 and 3) share one
// stimulus stream and each has its own memory read model and scoreboard.
module tb_bist_addr_gen;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int EW = 21;  // {issue cycle[15:0], addr[3:0], expected is_equal}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT stimulus and outputs ----------------
  logic          reset, preset, en, up_down, wr_phase, inv;
  logic [1:0]    pat_sel;
  logic [DW-1:0] mem_rdata1, mem_rdata3;
  logic [AW-1:0] addr1, addr3, fail_addr1, fail_addr3;
  logic [DW-1:0] mem_wdata1, mem_wdata3;
  logic          mem_we1, mem_we3, carry1, carry3;
  logic          is_equal1, is_equal3, cmp_valid1, cmp_valid3;
  logic          fail_seen1, fail_seen3;

  bist_addr_gen #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst), .reset(reset), .preset(preset), .en(en),
    .up_down(up_down), .wr_phase(wr_phase), .pat_sel(pat_sel), .inv(inv),
    .mem_rdata(mem_rdata1), .addr(addr1), .mem_we(mem_we1),
    .mem_wdata(mem_wdata1), .carry(carry1), .is_equal(is_equal1),
    .cmp_valid(cmp_valid1), .fail_seen(fail_seen1), .fail_addr(fail_addr1)
  );

  bist_addr_gen #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst), .reset(reset), .preset(preset), .en(en),
    .up_down(up_down), .wr_phase(wr_phase), .pat_sel(pat_sel), .inv(inv),
    .mem_rdata(mem_rdata3), .addr(addr3), .mem_we(mem_we3),
    .mem_wdata(mem_wdata3), .carry(carry3), .is_equal(is_equal3),
    .cmp_valid(cmp_valid3), .fail_seen(fail_seen3), .fail_addr(fail_addr3)
  );

  // ---------------- memory model (read latency 1 and 3) ----------------
  logic [DW-1:0] mem [16];
  logic [AW-1:0] dly1 = '0;
  logic [AW-1:0] dly3 [3] = '{default: '0};

  always @(posedge clk) begin
    dly1    <= addr1;
    dly3[0] <= addr3;
    dly3[1] <= dly3[0];
    dly3[2] <= dly3[1];
  end
  assign mem_rdata1 = mem[dly1];
  assign mem_rdata3 = mem[dly3[2]];

  // ---------------- reference model state ----------------
  logic [AW-1:0] m_addr;
  logic          meq [2];
  logic          mf  [2];
  logic [AW-1:0] mfa [2];
  logic [EW-1:0] exp_q [2][$];

  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [DW-1:0] model_pat(input logic [AW-1:0] a,
                                              input logic [1:0] s,
                                              input logic v);
    logic [DW-1:0] p;
    case (s)
      2'b00:   p = 8'h00;
      2'b01:   p = 8'hFF;
      2'b10:   p = a[0] ? 8'hAA : 8'h55;
      default: p = {4'h0, a};
    endcase
    return v ? ~p : p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      exp_q[k].delete();
      meq[k] = 1'b1;
      mf[k]  = 1'b0;
      mfa[k] = '0;
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic          mon_due, mon_cv, mon_ie, mon_fs;
  logic [AW-1:0] mon_fa;
  logic [EW-1:0] mon_e;
  int            mon_lat;

  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        mon_lat = (k == 0) ? 1 : 3;
        mon_cv  = (k == 0) ? cmp_valid1 : cmp_valid3;
        mon_ie  = (k == 0) ? is_equal1  : is_equal3;
        mon_fs  = (k == 0) ? fail_seen1 : fail_seen3;
        mon_fa  = (k == 0) ? fail_addr1 : fail_addr3;
        mon_due = (exp_q[k].size() > 0) &&
                  (exp_q[k][0][20:5] == 16'(cyc - mon_lat - 1));
        chk($sformatf("cmp_valid[lat%0d]", mon_lat), 32'(mon_cv), 32'(mon_due));
        if (mon_due) begin
          mon_e = exp_q[k].pop_front();
          meq[k] = mon_e[0];
          if (!mon_e[0] && !mf[k]) begin
            mf[k]  = 1'b1;
            mfa[k] = mon_e[4:1];
          end
        end
        chk($sformatf("is_equal[lat%0d]", mon_lat),  32'(mon_ie), 32'(meq[k]));
        chk($sformatf("fail_seen[lat%0d]", mon_lat), 32'(mon_fs), 32'(mf[k]));
        chk($sformatf("fail_addr[lat%0d]", mon_lat), 32'(mon_fa), 32'(mfa[k]));
      end
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; drives one cycle, checks combinational write outputs,
  // pushes read expectations, then checks registered addr/carry after the edge.
  task automatic cycle(input logic e, input logic ud, input logic wr,
                       input logic rs, input logic ps);
    logic [DW-1:0] p;
    logic          exp_we, exp_carry;
    en = e; up_down = ud; wr_phase = wr; reset = rs; preset = ps;
    #1;
    p = model_pat(m_addr, pat_sel, inv);
    exp_we = e & wr & ~rs & ~ps;
    chk("mem_we[lat1]", 32'(mem_we1), 32'(exp_we));
    chk("mem_we[lat3]", 32'(mem_we3), 32'(exp_we));
    if (exp_we) begin
      chk("mem_wdata[lat1]", 32'(mem_wdata1), 32'(p));
      chk("mem_wdata[lat3]", 32'(mem_wdata3), 32'(p));
    end
    if (e && !wr && !rs && !ps) begin
      for (int k = 0; k < 2; k++) begin
        exp_q[k].push_back({16'(cyc), m_addr, (mem[m_addr] == p)});
      end
    end
    exp_carry = e & ~rs & ~ps & ((ud && m_addr == 4'hF) || (!ud && m_addr == 4'h0));
    @(posedge clk);
    if (rs) begin
      m_addr = '0;
      model_clear();
    end else if (ps) begin
      m_addr = 4'hF;
    end else if (e) begin
      m_addr = ud ? m_addr + 4'd1 : m_addr - 4'd1;
    end
    #1;
    chk("addr[lat1]",  32'(addr1),  32'(m_addr));
    chk("addr[lat3]",  32'(addr3),  32'(m_addr));
    chk("carry[lat1]", 32'(carry1), 32'(exp_carry));
    chk("carry[lat3]", 32'(carry3), 32'(exp_carry));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    reset = 1'b0; preset = 1'b0; en = 1'b0; up_down = 1'b1;
    wr_phase = 1'b0; pat_sel = 2'b00; inv = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    m_addr = '0;
    model_clear();
    @(posedge clk); #1;

    // Reset state
    chk("rst addr",      32'(addr1),      32'h0);
    chk("rst carry",     32'(carry1),     32'h0);
    chk("rst is_equal",  32'(is_equal1),  32'h1);
    chk("rst cmp_valid", 32'(cmp_valid3), 32'h0);
    chk("rst fail_seen", 32'(fail_seen3), 32'h0);
    chk("rst fail_addr", 32'(fail_addr3), 32'h0);
    rst = 1'b0;

    // Up sweep of back-to-back reads on clean memory, pattern zeros
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    chk("up drain[lat1]", 32'(exp_q[0].size()), 32'h0);
    chk("up drain[lat3]", 32'(exp_q[1].size()), 32'h0);

    // Down sweep of writes from preset, then reset+preset together
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("rst+preset addr", 32'(addr1), 32'h0);

    // Write patterns: checkerboard at 0 and 1, then complemented address
    pat_sel = 2'b10; inv = 1'b0;
    en = 1'b1; up_down = 1'b1; wr_phase = 1'b1; #1;
    chk("chk wdata@0", 32'(mem_wdata1), 32'h55);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    en = 1'b1; #1;
    chk("chk wdata@1", 32'(mem_wdata3), 32'hAA);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    pat_sel = 2'b11; inv = 1'b1;
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    en = 1'b1; #1;
    chk("addr inv wdata@3", 32'(mem_wdata1), 32'hFC);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // Fault capture: corrupt 6 and 9, sweep reads, then controller reset
    pat_sel = 2'b00; inv = 1'b0;
    mem[6] = 8'h01;
    mem[9] = 8'h01;
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    chk("fault fail_seen[lat1]", 32'(fail_seen1), 32'h1);
    chk("fault fail_addr[lat1]", 32'(fail_addr1), 32'h6);
    chk("fault fail_seen[lat3]", 32'(fail_seen3), 32'h1);
    chk("fault fail_addr[lat3]", 32'(fail_addr3), 32'h6);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("clr fail_seen", 32'(fail_seen3), 32'h0);
    chk("clr fail_addr", 32'(fail_addr1), 32'h0);
    idle(2);

    // Async reset mid-sweep with reads in flight (ones pattern mismatches)
    pat_sel = 2'b01;
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre-rst addr",      32'(addr1),      32'h5);
    chk("pre-rst fail_seen", 32'(fail_seen1), 32'h1);
    en = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst addr[lat1]",      32'(addr1),      32'h0);
    chk("arst addr[lat3]",      32'(addr3),      32'h0);
    chk("arst is_equal[lat1]",  32'(is_equal1),  32'h1);
    chk("arst fail_seen[lat1]", 32'(fail_seen1), 32'h0);
    chk("arst fail_seen[lat3]", 32'(fail_seen3), 32'h0);
    model_clear();
    m_addr = '0;
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
